// File: rtl/id_ex_reg_if.sv
// id_ex_reg_if: bundle of the decode-side inputs, hazard/stall controls and the registered
// EX-stage outputs of the ID/EX pipeline register.
//   master : drives Id*, Flush, MemStall; observes StallOut, Ex*, BubbleCount (decode side / bench)
//   slave  : the pipeline register itself
interface id_ex_reg_if #(
   parameter int unsigned BUBBLE_CNT_W = 16
);
   // decode slot
   logic        IdValid;
   logic [4:0]  IdRsAddr;
   logic [4:0]  IdRtAddr;
   logic        IdUsesRs;
   logic        IdUsesRt;
   logic [4:0]  IdDstAddr;
   logic [31:0] IdRsData;
   logic [31:0] IdRtData;
   logic [31:0] IdImm;
   logic [31:0] IdPc4;
   logic [3:0]  IdAluOp;
   logic        IdAluSrc;
   logic        IdRegWrite;
   logic        IdMemRead;
   logic        IdMemWrite;
   logic        IdMemToReg;
   // pipeline control
   logic        Flush;
   logic        MemStall;
   logic        StallOut;
   // EX-stage copies
   logic        ExValid;
   logic [4:0]  ExRsAddr;
   logic [4:0]  ExRtAddr;
   logic [4:0]  ExDstAddr;
   logic [31:0] ExRsData;
   logic [31:0] ExRtData;
   logic [31:0] ExImm;
   logic [31:0] ExPc4;
   logic [3:0]  ExAluOp;
   logic        ExAluSrc;
   logic        ExRegWrite;
   logic        ExMemRead;
   logic        ExMemWrite;
   logic        ExMemToReg;
   logic [BUBBLE_CNT_W-1:0] BubbleCount;

   modport master (
      output IdValid, IdRsAddr, IdRtAddr, IdUsesRs, IdUsesRt, IdDstAddr, IdRsData, IdRtData,
             IdImm, IdPc4, IdAluOp, IdAluSrc, IdRegWrite, IdMemRead, IdMemWrite, IdMemToReg,
             Flush, MemStall,
      input  StallOut, ExValid, ExRsAddr, ExRtAddr, ExDstAddr, ExRsData, ExRtData, ExImm, ExPc4,
             ExAluOp, ExAluSrc, ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg, BubbleCount
   );

   modport slave (
      input  IdValid, IdRsAddr, IdRtAddr, IdUsesRs, IdUsesRt, IdDstAddr, IdRsData, IdRtData,
             IdImm, IdPc4, IdAluOp, IdAluSrc, IdRegWrite, IdMemRead, IdMemWrite, IdMemToReg,
             Flush, MemStall,
      output StallOut, ExValid, ExRsAddr, ExRtAddr, ExDstAddr, ExRsData, ExRtData, ExImm, ExPc4,
             ExAluOp, ExAluSrc, ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg, BubbleCount
   );
endinterface

// File: rtl/id_ex_reg.sv
// id_ex_reg: ID/EX pipeline register downstream of the register file.
// Captures operand data, decoded control and immediate on each rising clk and presents them
// to EX. Detects load-use hazards (inserting a bubble and stalling upstream), freezes on a
// downstream memory stall, and turns the decode slot into a bubble on a taken branch flush.
// Ports:
//   clk   : pipeline clock, sampled on posedge (RF writes on negedge)
//   rst_n : asynchronous active-low reset, clears all EX outputs and the bubble counter
//   bus   : id_ex_reg_if slave - Id* inputs, Flush/MemStall, StallOut, Ex* outputs, BubbleCount
module id_ex_reg #(
   parameter int unsigned BUBBLE_CNT_W = 16
) (
   input logic       clk,
   input logic       rst_n,
   id_ex_reg_if.slave bus
);

   typedef struct packed {
      logic        valid;
      logic [4:0]  rs_addr;
      logic [4:0]  rt_addr;
      logic [4:0]  dst_addr;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm;
      logic [31:0] pc4;
      logic [3:0]  alu_op;
      logic        alu_src;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        mem_to_reg;
   } ex_t;

   ex_t                     ex_q, ex_d, id_fields;
   logic [BUBBLE_CNT_W-1:0] cnt_q, cnt_d;
   logic                    load_use;
   logic                    rs_hit, rt_hit;

   always_comb begin
      id_fields = '{
         valid:      bus.IdValid,
         rs_addr:    bus.IdRsAddr,
         rt_addr:    bus.IdRtAddr,
         dst_addr:   bus.IdDstAddr,
         rs_data:    bus.IdRsData,
         rt_data:    bus.IdRtData,
         imm:        bus.IdImm,
         pc4:        bus.IdPc4,
         alu_op:     bus.IdAluOp,
         alu_src:    bus.IdAluSrc,
         reg_write:  bus.IdRegWrite,
         mem_read:   bus.IdMemRead,
         mem_write:  bus.IdMemWrite,
         mem_to_reg: bus.IdMemToReg
      };
   end

   // A load in EX whose result a valid decode-slot reader needs; $0 is hardwired so never stalls.
   always_comb begin
      rs_hit   = bus.IdUsesRs & (bus.IdRsAddr == ex_q.dst_addr);
      rt_hit   = bus.IdUsesRt & (bus.IdRtAddr == ex_q.dst_addr);
      load_use = bus.IdValid & ex_q.valid & ex_q.mem_read & (ex_q.dst_addr != 5'd0) &
                 (rs_hit | rt_hit);
   end

   assign bus.StallOut = bus.MemStall | (load_use & ~bus.Flush);

   // Flush wins over MemStall: the branch owner guarantees EX is draining.
   always_comb begin
      ex_d  = ex_q;
      cnt_d = cnt_q;
      if (bus.Flush) begin
         ex_d = '0;
      end else if (bus.MemStall) begin
         ex_d = ex_q;
      end else if (load_use) begin
         ex_d = '0;
         if (cnt_q != '1) begin
            cnt_d = cnt_q + BUBBLE_CNT_W'(1);
         end
      end else begin
         ex_d = id_fields;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q  <= '0;
         cnt_q <= '0;
      end else begin
         ex_q  <= ex_d;
         cnt_q <= cnt_d;
      end
   end

   assign bus.ExValid     = ex_q.valid;
   assign bus.ExRsAddr    = ex_q.rs_addr;
   assign bus.ExRtAddr    = ex_q.rt_addr;
   assign bus.ExDstAddr   = ex_q.dst_addr;
   assign bus.ExRsData    = ex_q.rs_data;
   assign bus.ExRtData    = ex_q.rt_data;
   assign bus.ExImm       = ex_q.imm;
   assign bus.ExPc4       = ex_q.pc4;
   assign bus.ExAluOp     = ex_q.alu_op;
   assign bus.ExAluSrc    = ex_q.alu_src;
   assign bus.ExRegWrite  = ex_q.reg_write;
   assign bus.ExMemRead   = ex_q.mem_read;
   assign bus.ExMemWrite  = ex_q.mem_write;
   assign bus.ExMemToReg  = ex_q.mem_to_reg;
   assign bus.BubbleCount = cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// tb_id_ex_reg: self-checking bench for id_ex_reg. Two instances share identical stimulus:
// one with the default 16-bit bubble counter and one with a 2-bit counter for saturation.
module tb_id_ex_reg;

   typedef struct packed {
      logic        valid;
      logic [4:0]  rs_addr;
      logic [4:0]  rt_addr;
      logic        uses_rs;
      logic        uses_rt;
      logic [4:0]  dst_addr;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm;
      logic [31:0] pc4;
      logic [3:0]  alu_op;
      logic        alu_src;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        mem_to_reg;
   } id_t;

   typedef struct packed {
      logic        valid;
      logic [4:0]  rs_addr;
      logic [4:0]  rt_addr;
      logic [4:0]  dst_addr;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm;
      logic [31:0] pc4;
      logic [3:0]  alu_op;
      logic        alu_src;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        mem_to_reg;
   } ex_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   id_t  id;
   logic flush;
   logic mem_stall;

   // reference model state
   ex_t         m_ex;
   int unsigned m_cnt;

   int checks = 0;
   int failures = 0;

   logic [1:0] sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

   always #5 clk = ~clk;

   id_ex_reg_if #(.BUBBLE_CNT_W(16)) bus16 ();
   id_ex_reg_if #(.BUBBLE_CNT_W(2))  bus2 ();

   id_ex_reg #(.BUBBLE_CNT_W(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
   id_ex_reg #(.BUBBLE_CNT_W(2))  u_dut2  (.clk(clk), .rst_n(rst_n), .bus(bus2));

   assign bus16.IdValid    = id.valid;      assign bus2.IdValid    = id.valid;
   assign bus16.IdRsAddr   = id.rs_addr;    assign bus2.IdRsAddr   = id.rs_addr;
   assign bus16.IdRtAddr   = id.rt_addr;    assign bus2.IdRtAddr   = id.rt_addr;
   assign bus16.IdUsesRs   = id.uses_rs;    assign bus2.IdUsesRs   = id.uses_rs;
   assign bus16.IdUsesRt   = id.uses_rt;    assign bus2.IdUsesRt   = id.uses_rt;
   assign bus16.IdDstAddr  = id.dst_addr;   assign bus2.IdDstAddr  = id.dst_addr;
   assign bus16.IdRsData   = id.rs_data;    assign bus2.IdRsData   = id.rs_data;
   assign bus16.IdRtData   = id.rt_data;    assign bus2.IdRtData   = id.rt_data;
   assign bus16.IdImm      = id.imm;        assign bus2.IdImm      = id.imm;
   assign bus16.IdPc4      = id.pc4;        assign bus2.IdPc4      = id.pc4;
   assign bus16.IdAluOp    = id.alu_op;     assign bus2.IdAluOp    = id.alu_op;
   assign bus16.IdAluSrc   = id.alu_src;    assign bus2.IdAluSrc   = id.alu_src;
   assign bus16.IdRegWrite = id.reg_write;  assign bus2.IdRegWrite = id.reg_write;
   assign bus16.IdMemRead  = id.mem_read;   assign bus2.IdMemRead  = id.mem_read;
   assign bus16.IdMemWrite = id.mem_write;  assign bus2.IdMemWrite = id.mem_write;
   assign bus16.IdMemToReg = id.mem_to_reg; assign bus2.IdMemToReg = id.mem_to_reg;
   assign bus16.Flush      = flush;         assign bus2.Flush      = flush;
   assign bus16.MemStall   = mem_stall;     assign bus2.MemStall   = mem_stall;

   function automatic ex_t obs16();
      return {bus16.ExValid, bus16.ExRsAddr, bus16.ExRtAddr, bus16.ExDstAddr, bus16.ExRsData,
              bus16.ExRtData, bus16.ExImm, bus16.ExPc4, bus16.ExAluOp, bus16.ExAluSrc,
              bus16.ExRegWrite, bus16.ExMemRead, bus16.ExMemWrite, bus16.ExMemToReg};
   endfunction

   function automatic ex_t obs2();
      return {bus2.ExValid, bus2.ExRsAddr, bus2.ExRtAddr, bus2.ExDstAddr, bus2.ExRsData,
              bus2.ExRtData, bus2.ExImm, bus2.ExPc4, bus2.ExAluOp, bus2.ExAluSrc,
              bus2.ExRegWrite, bus2.ExMemRead, bus2.ExMemWrite, bus2.ExMemToReg};
   endfunction

   // What EX should hold after a plain load of the decode slot.
   function automatic ex_t to_ex(id_t i);
      ex_t e;
      e.valid      = i.valid;
      e.rs_addr    = i.rs_addr;
      e.rt_addr    = i.rt_addr;
      e.dst_addr   = i.dst_addr;
      e.rs_data    = i.rs_data;
      e.rt_data    = i.rt_data;
      e.imm        = i.imm;
      e.pc4        = i.pc4;
      e.alu_op     = i.alu_op;
      e.alu_src    = i.alu_src;
      e.reg_write  = i.reg_write;
      e.mem_read   = i.mem_read;
      e.mem_write  = i.mem_write;
      e.mem_to_reg = i.mem_to_reg;
      return e;
   endfunction

   // Does the current decode instruction need the result of the load sitting in EX?
   function automatic bit model_hazard();
      bit needs;
      if (!(id.valid && m_ex.valid && m_ex.mem_read) || m_ex.dst_addr == 5'd0) return 1'b0;
      needs = (id.uses_rs && id.rs_addr == m_ex.dst_addr) ||
              (id.uses_rt && id.rt_addr == m_ex.dst_addr);
      return needs;
   endfunction

   function automatic bit model_stall();
      return mem_stall || (model_hazard() && !flush);
   endfunction

   function automatic int unsigned exp_cnt(int unsigned max);
      return (m_cnt > max) ? max : m_cnt;
   endfunction

   function automatic id_t rand_id();
      id_t r;
      r.valid      = ($urandom_range(0, 3) != 0);
      r.rs_addr    = 5'($urandom_range(0, 3));
      r.rt_addr    = 5'($urandom_range(0, 3));
      r.uses_rs    = 1'($urandom_range(0, 1));
      r.uses_rt    = 1'($urandom_range(0, 1));
      r.dst_addr   = 5'($urandom_range(0, 3));
      r.rs_data    = $urandom;
      r.rt_data    = $urandom;
      r.imm        = $urandom;
      r.pc4        = $urandom;
      r.alu_op     = 4'($urandom);
      r.alu_src    = 1'($urandom);
      r.reg_write  = 1'($urandom);
      r.mem_read   = ($urandom_range(0, 2) == 0);
      r.mem_write  = 1'($urandom);
      r.mem_to_reg = 1'($urandom);
      return r;
   endfunction

   function automatic id_t make_lw(logic [4:0] dst);
      id_t r = '0;
      r.valid      = 1'b1;
      r.rs_addr    = 5'd1;
      r.uses_rs    = 1'b1;
      r.dst_addr   = dst;
      r.imm        = 32'h10;
      r.pc4        = 32'h400;
      r.alu_src    = 1'b1;
      r.reg_write  = 1'b1;
      r.mem_read   = 1'b1;
      r.mem_to_reg = 1'b1;
      return r;
   endfunction

   function automatic id_t make_reader(logic [4:0] rs, logic use_rs, logic [4:0] rt,
                                       logic use_rt);
      id_t r = '0;
      r.valid     = 1'b1;
      r.rs_addr   = rs;
      r.uses_rs   = use_rs;
      r.rt_addr   = rt;
      r.uses_rt   = use_rt;
      r.dst_addr  = 5'd10;
      r.rs_data   = $urandom;
      r.rt_data   = $urandom;
      r.pc4       = 32'h404;
      r.alu_op    = 4'd2;
      r.reg_write = 1'b1;
      return r;
   endfunction

   // One rising edge; the model applies the rules using the inputs stable at that edge.
   task automatic tick();
      bit hz;
      @(posedge clk);
      hz = model_hazard();
      if (flush) begin
         m_ex = '0;
      end else if (!mem_stall) begin
         if (hz) begin
            m_ex = '0;
            m_cnt++;
         end else begin
            m_ex = to_ex(id);
         end
      end
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      flush = 1'b0;
      mem_stall = 1'b0;
      id = '0;
      m_ex = '0;
      m_cnt = 0;
      #2;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      // still inside the power-on reset
      checks++;
      if (obs16() !== '0 || bus16.BubbleCount !== 16'd0 || bus16.StallOut !== 1'b0) begin
         failures++;
         $display("FAIL por_state: ex=%h cnt=%0d stall=%b required all zero", obs16(),
                  bus16.BubbleCount, bus16.StallOut);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         id = rand_id();
         id.mem_read = 1'b0;
         tick();
      end
      id = rand_id();
      id.valid = 1'b1;
      id.rs_addr = 5'd7;
      id.dst_addr = 5'd7;
      // assert mid-cycle, clear of any clock edge
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      m_ex = '0;
      m_cnt = 0;
      #1;
      checks++;
      if (obs16() !== '0 || obs2() !== '0) begin
         failures++;
         $display("FAIL async_reset_ex: got %h required 0", obs16());
      end
      checks++;
      if (bus16.BubbleCount !== 16'd0 || bus2.BubbleCount !== 2'd0 || bus16.StallOut !== 1'b0)
      begin
         failures++;
         $display("FAIL async_reset_cnt: cnt=%0d stall=%b required 0/0", bus16.BubbleCount,
                  bus16.StallOut);
      end
      @(negedge clk);
      rst_n = 1'b1;
      id = '0;
      id.valid = 1'b1;
      id.rs_data = 32'h1234_5678;
      tick();
      checks++;
      if (bus16.ExRsData !== 32'h1234_5678 || bus16.ExValid !== 1'b1) begin
         failures++;
         $display("FAIL first_load: rsdata=%h valid=%b required 12345678/1", bus16.ExRsData,
                  bus16.ExValid);
      end
   endtask

   task automatic test_load_use();
      int unsigned cnt0;
      id = '0;
      tick();
      id = make_lw(5'd8);
      tick();
      cnt0 = m_cnt;
      id = make_reader(5'd8, 1'b1, 5'd2, 1'b1);
      #1;
      checks++;
      if (bus16.StallOut !== 1'b1) begin
         failures++;
         $display("FAIL lu_stall: got %b required 1", bus16.StallOut);
      end
      tick();
      checks++;
      if (obs16() !== '0) begin
         failures++;
         $display("FAIL lu_bubble: got %h required 0", obs16());
      end
      checks++;
      if (bus16.BubbleCount !== 16'(cnt0 + 1)) begin
         failures++;
         $display("FAIL lu_cnt: got %0d required %0d", bus16.BubbleCount, cnt0 + 1);
      end
      #1;
      checks++;
      if (bus16.StallOut !== 1'b0) begin
         failures++;
         $display("FAIL lu_stall_clear: got %b required 0", bus16.StallOut);
      end
      tick();
      checks++;
      if (obs16() !== to_ex(id)) begin
         failures++;
         $display("FAIL lu_reload: got %h required %h", obs16(), to_ex(id));
      end
   endtask

   task automatic test_no_hazard();
      int unsigned cnt0;
      cnt0 = m_cnt;
      id = make_lw(5'd0);
      tick();
      id = make_reader(5'd0, 1'b1, 5'd0, 1'b1);
      #1;
      checks++;
      if (bus16.StallOut !== 1'b0) begin
         failures++;
         $display("FAIL r0_stall: got %b required 0", bus16.StallOut);
      end
      tick();
      checks++;
      if (obs16() !== to_ex(id) || bus16.BubbleCount !== 16'(cnt0)) begin
         failures++;
         $display("FAIL r0_load: got %h cnt=%0d required %h cnt=%0d", obs16(),
                  bus16.BubbleCount, to_ex(id), cnt0);
      end
      id = make_lw(5'd9);
      tick();
      id = make_reader(5'd4, 1'b1, 5'd9, 1'b0);
      #1;
      checks++;
      if (bus16.StallOut !== 1'b0) begin
         failures++;
         $display("FAIL unused_rt_stall: got %b required 0", bus16.StallOut);
      end
      tick();
      checks++;
      if (obs16() !== to_ex(id) || bus16.BubbleCount !== 16'(cnt0)) begin
         failures++;
         $display("FAIL unused_rt_load: got %h cnt=%0d required %h cnt=%0d", obs16(),
                  bus16.BubbleCount, to_ex(id), cnt0);
      end
   endtask

   task automatic test_flush_priority();
      int unsigned cnt0;
      id = make_lw(5'd5);
      tick();
      cnt0 = m_cnt;
      id = make_reader(5'd5, 1'b1, 5'd1, 1'b0);
      mem_stall = 1'b1;
      flush = 1'b1;
      #1;
      checks++;
      if (bus16.StallOut !== 1'b1) begin
         failures++;
         $display("FAIL flush_stallout: got %b required 1", bus16.StallOut);
      end
      tick();
      checks++;
      if (obs16() !== '0 || bus16.BubbleCount !== 16'(cnt0)) begin
         failures++;
         $display("FAIL flush_bubble: got %h cnt=%0d required 0 cnt=%0d", obs16(),
                  bus16.BubbleCount, cnt0);
      end
      flush = 1'b0;
      mem_stall = 1'b0;
   endtask

   task automatic test_mem_stall_hold();
      ex_t held;
      id = make_reader(5'd1, 1'b1, 5'd2, 1'b1);
      id.dst_addr = 5'd3;
      id.rs_data = 32'hA;
      tick();
      held = to_ex(id);
      mem_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         id = rand_id();
         #1;
         checks++;
         if (bus16.StallOut !== 1'b1) begin
            failures++;
            $display("FAIL hold_stallout[%0d]: got %b required 1", i, bus16.StallOut);
         end
         tick();
         checks++;
         if (obs16() !== held || bus16.ExRsData !== 32'hA) begin
            failures++;
            $display("FAIL hold[%0d]: got %h required %h", i, obs16(), held);
         end
      end
      mem_stall = 1'b0;
      id = rand_id();
      tick();
      checks++;
      if (obs16() !== to_ex(id)) begin
         failures++;
         $display("FAIL hold_release: got %h required %h", obs16(), to_ex(id));
      end
   endtask

   task automatic test_reset_mid_stall();
      id = make_lw(5'd6);
      tick();
      id = make_reader(5'd6, 1'b1, 5'd0, 1'b0);
      mem_stall = 1'b1;
      tick();
      rst_n = 1'b0;
      m_ex = '0;
      m_cnt = 0;
      #1;
      checks++;
      if (obs16() !== '0 || bus16.BubbleCount !== 16'd0) begin
         failures++;
         $display("FAIL mid_stall_reset: got %h cnt=%0d required 0", obs16(),
                  bus16.BubbleCount);
      end
      rst_n = 1'b1;
      mem_stall = 1'b0;
      #1;
      checks++;
      if (bus16.StallOut !== 1'b0) begin
         failures++;
         $display("FAIL mid_stall_restart: stall=%b required 0", bus16.StallOut);
      end
      tick();
      checks++;
      if (obs16() !== to_ex(id)) begin
         failures++;
         $display("FAIL mid_stall_reload: got %h required %h", obs16(), to_ex(id));
      end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         id = make_lw(5'(i + 1));
         tick();
         id = make_reader(5'(i + 1), 1'b1, 5'd0, 1'b0);
         tick();
         checks++;
         if (bus2.BubbleCount !== sat_exp[i] || bus16.BubbleCount !== 16'(i + 1)) begin
            failures++;
            $display("FAIL sat[%0d]: cnt2=%0d cnt16=%0d required %0d/%0d", i, bus2.BubbleCount,
                     bus16.BubbleCount, sat_exp[i], i + 1);
         end
         tick();
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         id = rand_id();
         flush = ($urandom_range(0, 7) == 0);
         mem_stall = ($urandom_range(0, 5) == 0);
         #1;
         checks++;
         if (bus16.StallOut !== model_stall() || bus2.StallOut !== model_stall()) begin
            failures++;
            $display("FAIL rnd_stall[%0d]: got %b/%b required %b", i, bus16.StallOut,
                     bus2.StallOut, model_stall());
         end
         tick();
         checks++;
         if (obs16() !== m_ex || obs2() !== m_ex) begin
            failures++;
            $display("FAIL rnd_ex[%0d]: got %h required %h", i, obs16(), m_ex);
         end
         checks++;
         if (bus16.BubbleCount !== 16'(exp_cnt(65535)) || bus2.BubbleCount !== 2'(exp_cnt(3)))
         begin
            failures++;
            $display("FAIL rnd_cnt[%0d]: got %0d/%0d required %0d/%0d", i, bus16.BubbleCount,
                     bus2.BubbleCount, exp_cnt(65535), exp_cnt(3));
         end
      end
      flush = 1'b0;
      mem_stall = 1'b0;
   endtask

   initial begin
      id = rand_id();
      flush = 1'b0;
      mem_stall = 1'b0;
      m_ex = '0;
      m_cnt = 0;
      #12;
      test_reset();
      test_load_use();
      test_no_hazard();
      test_flush_priority();
      test_mem_stall_hold();
      test_reset_mid_stall();
      test_saturation();
      do_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- ID/EX pipeline register that sits directly downstream of the register file (RF).
- Captures RsData/RtData plus decoded control and immediate at each rising clk, and presents them to the EX stage.
- Detects load-use hazards and inserts bubbles; honours a downstream memory stall and a branch flush from EX.
- Keeps a saturating count of bubbles it inserts, for performance monitoring.

Parameters:
- BUBBLE_CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  input  1  pipeline clock; this stage samples on posedge (RF writes on negedge).
- rst_n  input  1  reset, asynchronous, active-low.
- IdValid  input  1  decode slot holds a real instruction.
- IdRsAddr  input  5  rs field, same value driven to RF RsAddr.
- IdRtAddr  input  5  rt field, same value driven to RF RtAddr.
- IdUsesRs  input  1  instruction reads rs.
- IdUsesRt  input  1  instruction reads rt.
- IdDstAddr  input  5  destination register, already selected (rd/rt/31).
- IdRsData  input  32  RF RsData.
- IdRtData  input  32  RF RtData.
- IdImm  input  32  extended immediate.
- IdPc4  input  32  PC+4 of the instruction.
- IdAluOp  input  4  ALU operation.
- IdAluSrc  input  1  select immediate for ALU operand B.
- IdRegWrite  input  1  writes the register file.
- IdMemRead  input  1  load.
- IdMemWrite  input  1  store.
- IdMemToReg  input  1  writeback source is memory.
- Flush  input  1  branch/jump resolved taken in EX; kill the decode slot.
- MemStall  input  1  downstream busy; freeze this stage.
- StallOut  output  1  hold PC and IF/ID (combinational).
- ExValid, ExRsAddr, ExRtAddr, ExDstAddr, ExRsData, ExRtData, ExImm, ExPc4, ExAluOp, ExAluSrc, ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg  output  (widths match the Id* counterparts)  registered EX-stage copies.
- BubbleCount  output  BUBBLE_CNT_W  number of bubbles inserted, saturating.

Behaviour:
- Reset: while rst_n=0, all Ex* outputs and BubbleCount are 0, asynchronously; StallOut follows its equation from the zeroed state, giving 0 unless MemStall=1.
- LoadUse (combinational) = IdValid & ExValid & ExMemRead & (ExDstAddr!=0) & ((IdUsesRs & IdRsAddr==ExDstAddr) | (IdUsesRt & IdRtAddr==ExDstAddr)).
- StallOut = MemStall | (LoadUse & ~Flush).
- Posedge update, first matching rule wins:
  1. Flush=1 -> bubble. Flush beats MemStall, because the branch owner guarantees EX is draining.
  2. MemStall=1 -> hold every Ex* register and BubbleCount.
  3. LoadUse=1 -> bubble; the ID instruction is retained upstream and re-presented next cycle.
  4. Otherwise -> load every Ex* field from its Id* input; ExValid=IdValid.
- Bubble definition:
  - ExValid, ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg = 0.
  - ExAluOp, ExAluSrc = 0. Address, data, Imm and Pc4 fields = 0.
- Bubble counting: BubbleCount increments on a bubble from rule 3 only. Flush bubbles are not counted. At all-ones the counter holds.
- Latency: exactly 1 cycle from Id* to Ex*. There is no combinational path from Id* to Ex*.
- Register $0: never causes a hazard. IdRsData/IdRtData for $0 pass through unmodified; RF guarantees 0.
- No write-back bypass in this block. RF writes on negedge, so RsData/RtData sampled at posedge already reflect a write in the same cycle.
- IdValid=0 loads as a normal slot with ExValid=0. It never raises LoadUse.
- Back-to-back: after a LoadUse bubble, ExMemRead=0, so the re-presented instruction loads on the next cycle. A single load produces exactly one bubble.
- Reset mid-stall: on release, the pipeline restarts empty with StallOut=0.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with all Id* nonzero -> all Ex* = 0 and BubbleCount=0 immediately, with no clk edge; release, then one posedge with IdRsData=0x1234_5678, IdValid=1 -> ExRsData=0x1234_5678, ExValid=1.
- Load-use: cycle N loads lw (IdMemRead=1, IdDstAddr=8); N+1 ID has add with IdRsAddr=8, IdUsesRs=1 -> StallOut=1 during N+1, ExValid=0 after N+1 edge, BubbleCount=1, add loads at N+2 edge, StallOut=0 at N+2.
- No hazard on $0 or unused field: lw to $0 followed by a reader of $0; lw to $9 followed by an instruction with IdRtAddr=9 and IdUsesRt=0 -> StallOut=0, no bubble, BubbleCount unchanged.
- Flush over hazard and stall: LoadUse=1, MemStall=1 and Flush=1 in the same cycle -> StallOut=1 (from MemStall), next Ex* = bubble, BubbleCount unchanged.
- MemStall hold: Ex* holds add $3 with ExRsData=0xA; MemStall=1 for 3 cycles while Id* changes -> Ex* unchanged for 3 edges; after release the new Id* is loaded.
- Saturation: BUBBLE_CNT_W=2, force 5 load-use bubbles -> BubbleCount sequence 1,2,3,3,3.
